// File: rtl/fifo_pkg.sv
// Shared widths and defaults for the FIFO_top family (FIFO core, pointer
// logic and the read-side stream drain).
//   DATA_W        : FIFO data word width
//   CNT_W         : delivered-word counter width
//   BURST_LEN_DEF : default words per burst for out_last framing
//   BUF_DEPTH     : depth of the 2-entry output skid buffer
package fifo_pkg;
  localparam int DATA_W        = 5;
  localparam int CNT_W         = 16;
  localparam int BURST_LEN_DEF = 8;
  localparam int BUF_DEPTH     = 2;

  // Counter width for a modulo-n count; never zero so n=1 still gets a bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_buf2.sv
// 2-entry ordered stream buffer. slot[0] is the head; a pop shifts slot[1]
// down, and a push lands in the first free slot after this cycle's pop.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   push/push_data : write one word this edge
//   pop            : drop the head this edge (caller guarantees occ != 0)
//   occ            : number of valid entries, 0..2
//   head           : slot[0], zero after reset
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [BUF_DEPTH-1:0][W-1:0] slot;
  logic [1:0] occ_pop;
  logic [2:0] occ_nxt;

  assign occ_pop = occ - {1'b0, pop};
  assign occ_nxt = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
  assign head    = slot[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ  <= '0;
      slot <= '0;
    end else begin
      if (pop) slot[0] <= slot[1];
      // Later NBA wins: with occ==1, pop+push overwrites the shifted head.
      if (push) slot[occ_pop[0]] <= push_data;
      occ <= occ_nxt[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (occ_nxt <= 3'd2);
      assert (!(pop && occ == 2'd0));
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain for FIFO_top: pops the FIFO (one-cycle registered read
// latency) into a 2-entry buffer and presents a valid/ready stream.
// Every BURST_LEN-th delivered word carries out_last; words_out counts pops.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   fifo_empty/fifo_rd  : FIFO empty flag / read strobe
//   fifo_dout           : FIFO data, valid the cycle after fifo_rd
//   out_valid/out_ready : downstream handshake
//   out_data/out_last   : head word and end-of-burst marker
//   words_out           : words delivered since reset, wraps
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int N         = DATA_W,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CW        = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [N-1:0]  fifo_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_last,
  output logic [CW-1:0] words_out
);
  localparam int BW = cnt_w(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  logic          pending;
  logic [1:0]    occ;
  logic [BW-1:0] beat_cnt;
  logic          pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_last  = out_valid && (beat_cnt == BEAT_LAST);

  // Issue a read only if a slot is guaranteed free when the data arrives:
  // occ + pending < 2 + pop  <=>  space >= 1.
  assign fifo_rd = rst && !fifo_empty &&
                   (({1'b0, occ} + {2'b0, pending}) < (3'd2 + {2'b0, pop}));

  stream_buf2 #(.W(N)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pending),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (out_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending   <= 1'b0;
      beat_cnt  <= '0;
      words_out <= '0;
    end else begin
      pending <= fifo_rd;
      if (pop) begin
        beat_cnt  <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BW'(1);
        words_out <= words_out + CW'(1);
      end
    end
  end
endmodule
